// File: rtl/apb_uart_tx_fifo.sv
// APB-attached UART transmitter with a small transmit FIFO.
// Zero-wait-state APB slave: TXDATA (0x00) pushes a byte, STATUS (0x04)
// reports full/empty/busy/overflow, CTRL (0x08) selects stop bits and parity.
// Optional parity support is compiled in when UART_TX_PARITY_EN is defined;
// without it frames never carry a parity bit and CTRL bits 2:1 read 0.
module apb_uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // APB decode; every access finishes in its first access cycle
    logic access;
    logic wr_txdata;
    logic wr_ctrl;
    logic rd_status;

    assign access    = PSEL & PENABLE;
    assign wr_txdata = access & PWRITE & (PADDR == 8'h00);
    assign wr_ctrl   = access & PWRITE & (PADDR == 8'h08);
    assign rd_status = access & ~PWRITE & (PADDR == 8'h04);
    assign PREADY    = access & ~PRESET;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_reg;
    logic [PTR_W:0]       rd_ptr_reg;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 push;
    logic                 pop;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    // A push into a full FIFO still fits when the transmitter pops on the same edge
    assign push       = wr_txdata & (~fifo_full | pop);

    // Register file and transmitter state
    logic                 overflow_reg;
    logic [2:0]           ctrl_reg;
    state_t               state_reg, state_next;
    logic [BAUD_W-1:0]    baud_reg, baud_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 two_stop_reg, two_stop_next;
    logic                 tx_reg, tx_next;
    logic                 done;
    logic                 load;
    logic                 baud_end;
    logic                 busy;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_reg, par_en_next;
    logic                 par_bit_reg, par_bit_next;
`endif

    assign busy        = (state_reg != IDLE);
    assign o_Tx_Serial = tx_reg;
    assign o_Tx_Done   = done;

    // FIFO data array write port (no reset so it can map onto RAM)
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= PWDATA[DATA_BITS-1:0];
        end
    end

    // FIFO pointers, sticky overflow and CTRL register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
            ctrl_reg     <= 3'b000;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // A dropped push on the same edge as a STATUS read keeps overflow set
            if (wr_txdata & fifo_full & ~pop) begin
                overflow_reg <= 1'b1;
            end else if (rd_status) begin
                overflow_reg <= 1'b0;
            end
            if (wr_ctrl) begin
`ifdef UART_TX_PARITY_EN
                ctrl_reg <= PWDATA[2:0];
`else
                ctrl_reg <= {2'b00, PWDATA[0]};
`endif
            end
        end
    end

    // Read mux: combinational from PADDR during any read-select cycle
    always_comb begin
        PRDATA = 8'h00;
        if (PSEL & ~PWRITE & ~PRESET) begin
            case (PADDR)
                8'h04:   PRDATA = {4'b0000, overflow_reg, busy, fifo_empty, fifo_full};
                8'h08:   PRDATA = {5'b00000, ctrl_reg};
                default: PRDATA = 8'h00;
            endcase
        end
    end

    // Transmitter next-state, counters, shifter and serial line value
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        two_stop_next = two_stop_reg;
        tx_next       = tx_reg;
        done          = 1'b0;
        load          = 1'b0;
        pop           = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
`endif
        baud_end      = (baud_reg == BAUD_LAST);

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                        bit_next   = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_reg) begin
                            state_next = PARITY;
                            tx_next    = par_bit_reg;
                        end
`endif
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = STOP;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    // bit_reg counts stop bits here: last is 0 (one stop) or 1 (two stops)
                    if (bit_reg == BIT_W'(two_stop_reg)) begin
                        done = 1'b1;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                            bit_next   = '0;
                        end
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Frame launch: pop the head, snapshot CTRL so later writes wait for the next frame
        if (load) begin
            pop           = 1'b1;
            state_next    = START;
            baud_next     = '0;
            bit_next      = '0;
            tx_next       = 1'b0;
            shift_next    = fifo_head;
            two_stop_next = ctrl_reg[0];
`ifdef UART_TX_PARITY_EN
            par_en_next   = ctrl_reg[1];
            par_bit_next  = (^fifo_head) ^ ctrl_reg[2];
`endif
        end
    end

    // Transmitter state register; reset drives the line idle immediately
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            two_stop_reg <= 1'b0;
            tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            two_stop_reg <= two_stop_next;
            tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
`endif
        end
    end

endmodule

// File: doc/apb_uart_tx_fifo.md
APB_UART_TX_FIFO -- requirements
Module: apb_uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, PCLK cycles per serial bit (>=2).
REQ-002 SHALL have parameter DATA_BITS, default 8, frame data width (5..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of 2, >=2).
REQ-004 PCLK  input  1  clock; all logic on rising edge.
REQ-005 PRESET  input  1  reset, asynchronous, active-high.
REQ-006 PSEL  input  1  APB slave select.
REQ-007 PENABLE  input  1  APB access phase.
REQ-008 PWRITE  input  1  APB write (1) / read (0).
REQ-009 PADDR  input  8  register address.
REQ-010 PWDATA  input  8  write data.
REQ-011 PRDATA  output  8  read data.
REQ-012 PREADY  output  1  transfer complete.
REQ-013 o_Tx_Serial  output  1  serial line, idle high.
REQ-014 o_Tx_Done  output  1  one-cycle pulse per completed frame.

Function
REQ-015 PREADY SHALL equal PSEL&PENABLE (zero wait states); all accesses complete in one access cycle.
REQ-016 Address map: 0x00 TXDATA (write-only, push PWDATA[DATA_BITS-1:0]); 0x04 STATUS (read-only: bit0 full, bit1 empty, bit2 busy, bit3 overflow); 0x08 CTRL (read/write: bit0 two-stop, bit1 parity enable, bit2 odd parity); other addresses read 0, writes ignored.
REQ-017 Push SHALL occur on the edge where PSEL&PENABLE&PWRITE and PADDR==0x00.
REQ-018 Push while full SHALL be dropped and set sticky overflow, unless a pop occurs on the same edge, in which case push is accepted.
REQ-019 Read of STATUS SHALL return current flags and clear overflow on that edge; overflow set on the same edge wins.
REQ-020 PRDATA SHALL be combinational from PADDR when PSEL&~PWRITE, else 0.
REQ-021 FSM states IDLE, START, DATA, PARITY, STOP; o_Tx_Serial registered.
REQ-022 IDLE: line high; FIFO non-empty -> pop head, latch CTRL, go START; line low from next cycle.
REQ-023 START, each DATA bit (LSB first), PARITY and each STOP bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-024 DATA -> PARITY if latched parity enable, else STOP; PARITY bit = XOR of data (even) or its inverse (odd).
REQ-025 STOP SHALL emit 1 or 2 stop bits per latched two-stop; o_Tx_Done high the last STOP cycle.
REQ-026 End of STOP with FIFO non-empty SHALL pop and enter START directly (no idle gap); else IDLE.
REQ-027 busy SHALL be 1 in any state other than IDLE.
REQ-028 CTRL writes mid-frame SHALL affect only subsequent frames.

Reset
REQ-029 PRESET SHALL immediately force IDLE, o_Tx_Serial=1, o_Tx_Done=0, FIFO empty, overflow=0, CTRL=0, bit/baud counters=0, including mid-frame.
REQ-030 PRDATA and PREADY SHALL be 0 while PRESET is high.

Configuration
REQ-031 Macro UART_TX_PARITY_EN defined: PARITY state and CTRL bits 1..2 implemented per REQ-024.
REQ-032 Macro undefined: no PARITY state, CTRL bits 1..2 read 0 and ignore writes, frames never carry parity.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-033 Write 0xA5 to 0x00, CTRL=0 -> line: 4 low, bits 1,0,1,0,0,1,0,1 at 4 cycles each, 4 high; o_Tx_Done one pulse; STATUS=0x02 afterwards.
REQ-034 Write 0x55, 0x0F back-to-back -> second start bit immediately follows first stop bit, two o_Tx_Done pulses 40 cycles apart.
REQ-035 Six writes during first frame -> four accepted plus one freed by pop, sixth dropped, STATUS bit3=1; second STATUS read shows bit3=0.
REQ-036 CTRL=0x07 (macro defined), write 0x03 -> odd parity bit 1 after data, 8 stop cycles, frame 48 cycles; macro undefined -> CTRL reads 0x01, no parity bit.
REQ-037 Assert PRESET mid DATA bit 3 -> o_Tx_Serial high same cycle, STATUS=0x02 after release, no o_Tx_Done.
REQ-038 Read 0x0C -> PRDATA=0x00, PREADY=1; write 0x0C -> no state change.
